capture_sequencer: RTL and testbench

- Single-clock acquisition sequencer. Schedules a circular-buffer capture into the channel sample memories through arm, pre-trigger fill, trigger wait and post-trigger fill.
- Sits between the front-panel/host control registers and both channel memory write paths. One shared write address and write strobe drive both channels, so channel 1 and channel 2 captures stay sample-aligned.
- Reports the trigger address and capture status for the display readout logic.

---
 rtl/capture_sequencer.sv | 179 +++++++++++++++++
 tb/tb_capture_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_sequencer.sv
// rtl/capture_sequencer.sv - arm/pre/wait/post capture sequencer; HOLDOFF_EN adds trigger holdoff
module capture_sequencer #(
  parameter int ADDR_W       = 17,
  parameter int AUTO_TIMEOUT = 5000000,
  parameter int TO_W         = 23
) (
  input  logic              clk_50,
  input  logic              reset,
  input  logic              sample_tick,
  input  logic              arm,
  input  logic [1:0]        mode,
  input  logic              trig_sel,
  input  logic              trigger_1,
  input  logic              trigger_2,
  input  logic              force_trig,
  input  logic [ADDR_W-1:0] pretrig_len,
  input  logic [ADDR_W-1:0] posttrig_len,
`ifdef HOLDOFF_EN
  input  logic [15:0]       holdoff_len,
`endif
  input  logic              display_busy,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] trig_addr,
  output logic              capture_done,
  output logic              forced,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_WAIT = 3'd2,
    S_POST = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [TO_W-1:0]   TO_ONE   = TO_W'(1);
  localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(AUTO_TIMEOUT - 1);

  state_t            state_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [ADDR_W-1:0] trig_addr_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] pre_len_q;
  logic [ADDR_W-1:0] post_len_q;
  logic [TO_W-1:0]   to_q;
  logic              capture_done_q;
  logic              forced_q;
  logic              trig_lvl_q;
  logic              trig_prev_q;

  logic              capturing;
  logic              auto_mode;
  logic              single_mode;
  logic              trig_edge;
  logic              edge_ok;
  logic              timeout_hit;
  logic              trig_hit;
  logic              start_pre;
  logic [ADDR_W-1:0] cnt_d;

  assign capturing   = (state_q == S_PRE) || (state_q == S_WAIT) || (state_q == S_POST);
  assign auto_mode   = (mode == 2'b01);
  assign single_mode = (mode == 2'b10);

  // Both channel memories share this strobe, so channels stay sample-aligned
  assign wr_en = sample_tick & capturing;

  // Running sample count for the current phase, including this cycle's write
  assign cnt_d = wr_en ? (cnt_q + ADDR_ONE) : cnt_q;

  // Edge is taken from the registered level, hence one cycle of detect latency
  assign trig_edge = trig_lvl_q & ~trig_prev_q;

`ifdef HOLDOFF_EN
  logic [15:0] holdoff_q;

  assign edge_ok = trig_edge & (holdoff_q == 16'd0);

  // Holdoff counts clk_50 cycles from each PRE entry, independent of samples
  always_ff @(posedge clk_50) begin
    if (reset) begin
      holdoff_q <= 16'd0;
    end else if (start_pre) begin
      holdoff_q <= holdoff_len;
    end else if (holdoff_q != 16'd0) begin
      holdoff_q <= holdoff_q - 16'd1;
    end
  end
`else
  assign edge_ok = trig_edge;
`endif

  // Timeout counter saturates so a late switch into auto fires at once
  assign timeout_hit = auto_mode && (to_q == TO_LAST);
  assign trig_hit    = edge_ok | force_trig | timeout_hit;

  // Explicit arm restarts from any state; DONE also re-arms itself outside single mode
  assign start_pre = arm | ((state_q == S_DONE) & ~single_mode & ~display_busy);

  // Trigger level pipeline feeding the rising-edge detector
  always_ff @(posedge clk_50) begin
    if (reset) begin
      trig_lvl_q  <= 1'b0;
      trig_prev_q <= 1'b0;
    end else begin
      trig_lvl_q  <= trig_sel ? trigger_2 : trigger_1;
      trig_prev_q <= trig_lvl_q;
    end
  end

  // Capture FSM with its address, counters and registered status outputs
  always_ff @(posedge clk_50) begin
    if (reset) begin
      state_q        <= S_IDLE;
      wr_addr_q      <= '0;
      trig_addr_q    <= '0;
      cnt_q          <= '0;
      pre_len_q      <= '0;
      post_len_q     <= '0;
      to_q           <= '0;
      capture_done_q <= 1'b0;
      forced_q       <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_addr_q <= wr_addr_q + ADDR_ONE;
      end
      if (start_pre) begin
        state_q        <= S_PRE;
        cnt_q          <= '0;
        pre_len_q      <= pretrig_len;
        post_len_q     <= posttrig_len;
        capture_done_q <= 1'b0;
      end else begin
        case (state_q)
          S_PRE: begin
            if (cnt_d >= pre_len_q) begin
              state_q <= S_WAIT;
              cnt_q   <= '0;
              to_q    <= '0;
            end else begin
              cnt_q <= cnt_d;
            end
          end
          S_WAIT: begin
            if (trig_hit) begin
              state_q     <= S_POST;
              trig_addr_q <= wr_addr_q;
              forced_q    <= ~edge_ok;
              cnt_q       <= '0;
            end else if (to_q != TO_LAST) begin
              to_q <= to_q + TO_ONE;
            end
          end
          S_POST: begin
            if (cnt_d >= post_len_q) begin
              state_q        <= S_DONE;
              capture_done_q <= 1'b1;
              cnt_q          <= '0;
            end else begin
              cnt_q <= cnt_d;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign wr_addr      = wr_addr_q;
  assign trig_addr    = trig_addr_q;
  assign capture_done = capture_done_q;
  assign forced       = forced_q;
  assign state        = state_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// tb/tb_capture_sequencer.sv - randomized self-checking bench for capture_sequencer
module tb_capture_sequencer;

  localparam int AW = 8;
  localparam int AT = 16;

  logic          clk_50 = 1'b0;
  logic          reset = 1'b1;
  logic          sample_tick = 1'b0;
  logic          arm = 1'b0;
  logic [1:0]    mode = 2'b10;
  logic          trig_sel = 1'b0;
  logic          trigger_1 = 1'b0;
  logic          trigger_2 = 1'b0;
  logic          force_trig = 1'b0;
  logic [AW-1:0] pretrig_len = '0;
  logic [AW-1:0] posttrig_len = '0;
  logic          display_busy = 1'b1;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] trig_addr;
  logic          capture_done;
  logic          forced;
  logic [2:0]    state;

  int            vectors = 0;
  int            errors = 0;
  logic [AW-1:0] exp_addr = '0;

  capture_sequencer #(.ADDR_W(AW), .AUTO_TIMEOUT(AT), .TO_W(23)) dut (
    .clk_50(clk_50), .reset(reset), .sample_tick(sample_tick), .arm(arm), .mode(mode),
    .trig_sel(trig_sel), .trigger_1(trigger_1), .trigger_2(trigger_2), .force_trig(force_trig),
    .pretrig_len(pretrig_len), .posttrig_len(posttrig_len), .display_busy(display_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .trig_addr(trig_addr), .capture_done(capture_done),
    .forced(forced), .state(state)
  );

  always #5 clk_50 = ~clk_50;

  task automatic next_cycle();
    @(posedge clk_50);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    sample_tick = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge clk_50);
    if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
    vectors++;
    if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %0b expected 0", wr_en); end
    vectors++;
    if (wr_addr !== '0) begin errors++; $display("FAIL reset_wr_addr: got %0d expected 0", wr_addr); end
    vectors++;
    if (trig_addr !== '0) begin errors++; $display("FAIL reset_trig_addr: got %0d expected 0", trig_addr); end
    vectors++;
    if ({capture_done, forced} !== 2'b00) begin
      errors++; $display("FAIL reset_flags: got done=%0b forced=%0b expected 0 0", capture_done, forced);
    end
    vectors++;
    next_cycle();
    reset = 1'b0;
    sample_tick = 1'b0;
    exp_addr = '0;
    next_cycle();
  endtask

  // kind: 0 edge trigger, 1 force_trig, 2 edge and force together, 3 auto timeout
  task automatic test_capture(input int pre, input int post, input int tick_div, input int w,
                              input int kind, input logic sel, input logic [1:0] md, input logic noise);
    logic          tk [0:511];
    int            cum [0:511];
    int            p_end, d, d_end, r, exp_st;
    logic          lvl, exp_we, exp_forced;
    logic [AW-1:0] a0, exp_trig;
    a0 = exp_addr;
    tk[0] = 1'b0;
    cum[0] = 0;
    for (int i = 1; i < 512; i++) begin
      tk[i] = (tick_div <= 1) ? 1'b1 : ($urandom_range(0, tick_div - 1) == 0);
      cum[i] = cum[i-1] + int'(tk[i]);
    end
    p_end = -1;
    for (int c = 1; c < 512; c++) if (p_end < 0 && cum[c] >= pre) p_end = c;
    d = p_end + 1 + w;
    d_end = -1;
    for (int c = d + 1; c < 512; c++) if (d_end < 0 && cum[c] - cum[d] >= post) d_end = c;
    vectors++;
    if (p_end < 0 || d_end < 0 || d_end + 4 > 511) begin
      errors++;
      $display("FAIL model_budget: got p_end=%0d d_end=%0d expected both within 507", p_end, d_end);
      return;
    end
    exp_trig = a0 + AW'(cum[d-1]);
    exp_forced = (kind == 1 || kind == 3);
    r = (noise && p_end >= 2) ? int'($urandom_range(0, p_end - 2)) : -1;
    for (int c = 0; c <= d_end + 3; c++) begin
      arm = (c == 0);
      mode = md;
      trig_sel = sel;
      display_busy = 1'b1;
      pretrig_len = (c == 0) ? AW'(pre) : AW'($urandom);
      posttrig_len = (c == 0) ? AW'(post) : AW'($urandom);
      sample_tick = tk[c];
      lvl = (c == r) || ((kind == 0 || kind == 2) && c == d - 1);
      trigger_1 = sel ? 1'($urandom_range(0, 1)) : lvl;
      trigger_2 = sel ? lvl : 1'($urandom_range(0, 1));
      force_trig = (kind == 1 || kind == 2) && (c == d);
      @(negedge clk_50);
      exp_st = (c <= p_end) ? 1 : (c <= d) ? 2 : (c <= d_end) ? 3 : 4;
      exp_we = tk[c] && c >= 1 && c <= d_end;
      if (c >= 1) begin
        if (state !== 3'(exp_st)) begin
          errors++; $display("FAIL cap_state c=%0d: got %0d expected %0d", c, state, exp_st);
        end
        vectors++;
        if (wr_en !== exp_we) begin
          errors++; $display("FAIL cap_wr_en c=%0d: got %0b expected %0b", c, wr_en, exp_we);
        end
        vectors++;
        if (capture_done !== (exp_st == 4)) begin
          errors++; $display("FAIL cap_done c=%0d: got %0b expected %0b", c, capture_done, exp_st == 4);
        end
        vectors++;
      end
      if (exp_we) begin
        if (wr_addr !== exp_addr) begin
          errors++; $display("FAIL cap_wr_addr c=%0d: got %0d expected %0d", c, wr_addr, exp_addr);
        end
        vectors++;
        exp_addr = exp_addr + 1'b1;
      end
      if (c > d) begin
        if (trig_addr !== exp_trig) begin
          errors++; $display("FAIL cap_trig_addr c=%0d: got %0d expected %0d", c, trig_addr, exp_trig);
        end
        vectors++;
        if (forced !== exp_forced) begin
          errors++; $display("FAIL cap_forced c=%0d: got %0b expected %0b", c, forced, exp_forced);
        end
        vectors++;
      end
      next_cycle();
    end
    trigger_1 = 1'b0;
    trigger_2 = 1'b0;
    force_trig = 1'b0;
    sample_tick = 1'b0;
    arm = 1'b0;
  endtask

  task automatic test_single_capture();
    test_capture(4, 8, 1, 6, 0, 1'b0, 2'b10, 1'b0);
  endtask

  task automatic test_trig2_gating();
    test_capture(5, 2, 1, 3, 0, 1'b1, 2'b10, 1'b1);
    test_capture(0, 0, 2, 1, 0, 1'b1, 2'b11, 1'b0);
  endtask

  task automatic test_coincident_force();
    test_capture(3, 2, 2, 2, 2, 1'b0, 2'b00, 1'b0);
    test_capture(2, 3, 1, 0, 1, 1'b1, 2'b10, 1'b0);
  endtask

  task automatic test_random_captures();
    logic [1:0] md;
    for (int n = 0; n < 10; n++) begin
      case ($urandom_range(0, 2))
        0: md = 2'b00;
        1: md = 2'b10;
        default: md = 2'b11;
      endcase
      test_capture(int'($urandom_range(0, 6)), int'($urandom_range(0, 6)), int'($urandom_range(1, 3)),
                   int'($urandom_range(0, 6)), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                   md, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_auto_timeout();
    test_capture(2, 3, 1, AT - 1, 3, 1'b0, 2'b01, 1'b1);
  endtask

  task automatic test_auto_rearm();
    for (int c = 0; c < 4; c++) begin
      mode = 2'b01;
      display_busy = (c < 2);
      pretrig_len = AW'(5);
      sample_tick = 1'b0;
      @(negedge clk_50);
      if (state !== ((c < 3) ? 3'd4 : 3'd1)) begin
        errors++; $display("FAIL rearm_state c=%0d: got %0d expected %0d", c, state, (c < 3) ? 4 : 1);
      end
      vectors++;
      if (capture_done !== (c < 3)) begin
        errors++; $display("FAIL rearm_done c=%0d: got %0b expected %0b", c, capture_done, c < 3);
      end
      vectors++;
      next_cycle();
    end
    display_busy = 1'b1;
  endtask

  task automatic test_arm_restart();
    int            exp_st;
    logic [AW-1:0] a0;
    a0 = exp_addr;
    for (int c = 0; c <= 26; c++) begin
      mode = 2'b10;
      trig_sel = 1'b0;
      arm = (c == 0) || (c == 8);
      pretrig_len = (c == 0) ? AW'(3) : (c == 8) ? AW'(2) : AW'($urandom);
      posttrig_len = AW'(10);
      sample_tick = (c != 0);
      force_trig = (c == 4);
      trigger_1 = (c == 12);
      @(negedge clk_50);
      exp_st = (c <= 3) ? 1 : (c == 4) ? 2 : (c <= 8) ? 3 : (c <= 10) ? 1 : (c <= 13) ? 2 : (c <= 23) ? 3 : 4;
      if (c >= 1) begin
        if (state !== 3'(exp_st)) begin
          errors++; $display("FAIL restart_state c=%0d: got %0d expected %0d", c, state, exp_st);
        end
        vectors++;
        if (wr_en !== (exp_st != 4)) begin
          errors++; $display("FAIL restart_wr_en c=%0d: got %0b expected %0b", c, wr_en, exp_st != 4);
        end
        vectors++;
        if (exp_st != 4) begin
          if (wr_addr !== exp_addr) begin
            errors++; $display("FAIL restart_wr_addr c=%0d: got %0d expected %0d", c, wr_addr, exp_addr);
          end
          vectors++;
          exp_addr = exp_addr + 1'b1;
        end
      end
      if (c >= 5) begin
        if (trig_addr !== ((c <= 13) ? a0 + AW'(3) : a0 + AW'(12))) begin
          errors++; $display("FAIL restart_trig_addr c=%0d: got %0d expected %0d", c, trig_addr,
                             (c <= 13) ? a0 + AW'(3) : a0 + AW'(12));
        end
        vectors++;
        if (forced !== (c <= 13)) begin
          errors++; $display("FAIL restart_forced c=%0d: got %0b expected %0b", c, forced, c <= 13);
        end
        vectors++;
      end
      next_cycle();
    end
    arm = 1'b0;
    force_trig = 1'b0;
    trigger_1 = 1'b0;
    sample_tick = 1'b0;
  endtask

  task automatic test_reset_mid_post();
    for (int c = 0; c <= 8; c++) begin
      mode = 2'b10;
      arm = (c == 0);
      pretrig_len = AW'(1);
      posttrig_len = AW'(20);
      sample_tick = (c != 0);
      force_trig = (c == 2);
      reset = (c == 6) || (c == 7);
      @(negedge clk_50);
      if (c >= 1 && c <= 6) begin
        if (state !== ((c == 1) ? 3'd1 : (c == 2) ? 3'd2 : 3'd3)) begin
          errors++; $display("FAIL rst_pre_state c=%0d: got %0d expected %0d", c, state,
                             (c == 1) ? 1 : (c == 2) ? 2 : 3);
        end
        vectors++;
        if (wr_addr !== exp_addr) begin
          errors++; $display("FAIL rst_pre_wr_addr c=%0d: got %0d expected %0d", c, wr_addr, exp_addr);
        end
        vectors++;
        exp_addr = exp_addr + 1'b1;
      end
      if (c >= 7) begin
        if ({state, wr_en, capture_done, forced} !== 6'd0) begin
          errors++; $display("FAIL rst_flags c=%0d: got state=%0d wr_en=%0b done=%0b forced=%0b expected all 0",
                             c, state, wr_en, capture_done, forced);
        end
        vectors++;
        if ({wr_addr, trig_addr} !== '0) begin
          errors++; $display("FAIL rst_addrs c=%0d: got wr=%0d trig=%0d expected 0 0", c, wr_addr, trig_addr);
        end
        vectors++;
      end
      next_cycle();
    end
    exp_addr = '0;
    arm = 1'b0;
    force_trig = 1'b0;
    sample_tick = 1'b0;
  endtask

  task automatic test_wrap();
    int pre;
    pre = (254 - int'(exp_addr) - 2 + 512) % 256;
    if (pre < 1) pre += 256;
    test_capture(pre, 0, 1, 0, 1, 1'b0, 2'b10, 1'b0);
    @(negedge clk_50);
    if (wr_addr !== AW'(254)) begin
      errors++; $display("FAIL wrap_preload: got %0d expected 254", wr_addr);
    end
    vectors++;
    next_cycle();
    test_capture(4, 3, 1, 0, 0, 1'b0, 2'b10, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single_capture();
    test_trig2_gating();
    test_coincident_force();
    test_random_captures();
    test_auto_timeout();
    test_auto_rearm();
    test_arm_restart();
    test_reset_mid_post();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
